cdb_req_buffer: RTL and testbench

Requester-side endpoint of the CDB arbitration protocol. One instance sits at each functional-unit output. It queues completed results in a small circular FIFO, raises req to the CDB arbiter while an entry is pending, and drives the head entry onto its CDB lane and pops it in the cycle the arbiter grants it. It decouples FU completion timing from CDB availability and discards all pending results on a pipeline flush.

---
 rtl/cdb_req_buffer.sv | 77 +++++++
 tb/tb_cdb_req_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_req_buffer.sv
// Requester-side CDB endpoint: queues FU results in a circular FIFO, requests the
// CDB arbiter while non-empty, and broadcasts/pops the head entry on grant.
module cdb_req_buffer #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5,
    parameter int PREG_W    = 6,
    parameter int AREG_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROB_IDX_W-1:0]      in_rob_idx,
    input  logic [PREG_W-1:0]         in_pd,
    input  logic [AREG_W-1:0]         in_rd,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      req,
    input  logic                      grant,
    output logic                      cdb_valid,
    output logic [ROB_IDX_W-1:0]      cdb_rob_idx,
    output logic [PREG_W-1:0]         cdb_pd,
    output logic [AREG_W-1:0]         cdb_rd,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd;
        logic [AREG_W-1:0]    rd;
        logic [DATA_W-1:0]    data;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_e;
    logic [PW-1:0] head, tail;
    logic          push, pop;

    // req comes only from flops so the arbiter's grant path cannot loop back
    assign req      = (count != '0);
    assign in_ready = (count != FULL) && !rst;
    assign push     = in_valid && in_ready && !flush;
    assign pop      = req && grant && !flush;

    assign cdb_valid = pop;
    assign head_e    = mem[head];
    assign cdb_rob_idx = head_e.rob_idx;
    assign cdb_pd      = head_e.pd;
    assign cdb_rd      = head_e.rd;
    assign cdb_data    = head_e.data;

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= '{in_rob_idx, in_pd, in_rd, in_data};
    end

    // Full/empty is judged by count alone; pointers simply wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_cdb_req_buffer.sv
// Randomized and directed bench for cdb_req_buffer against a queue-based model.
module tb_cdb_req_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rob_idx;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, grant = 0;
    logic [4:0]  in_rob_idx = 0, in_rd = 0;
    logic [5:0]  in_pd = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, req, cdb_valid;
    logic [4:0]  cdb_rob_idx, cdb_rd;
    logic [5:0]  cdb_pd;
    logic [31:0] cdb_data;
    logic [2:0]  count;

    int checks = 0, failures = 0, spurious = 0;
    ent_t mq[$];

    cdb_req_buffer #(.DEPTH(DEPTH), .DATA_W(32), .ROB_IDX_W(5), .PREG_W(6), .AREG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rob_idx(in_rob_idx), .in_pd(in_pd), .in_rd(in_rd), .in_data(in_data),
        .req(req), .grant(grant), .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
        .cdb_pd(cdb_pd), .cdb_rd(cdb_rd), .cdb_data(cdb_data), .count(count)
    );

    always #5 clk = ~clk;

    // grant with no request is illegal in a real system; the bench counts each occurrence
    always @(negedge clk) if (!rst && grant && !req) spurious++;

    // Advance one clock and update the model from the protocol rules
    task automatic tick();
        bit pu, po;
        ent_t e;
        pu = in_valid && (mq.size() != DEPTH) && !flush;
        po = (mq.size() != 0) && grant && !flush;
        e = '{in_rob_idx, in_pd, in_rd, in_data};
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (po) void'(mq.pop_front());
            if (pu) mq.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v; in_data = d;
        in_rob_idx = 5'($urandom); in_pd = 6'($urandom); in_rd = 5'($urandom);
    endtask

    task automatic test_reset();
        grant = 1; #2;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", req); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_cdb_valid got=%0b exp=0", cdb_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        grant = 0;
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1; in_rob_idx = 3; in_pd = 12; in_rd = 7; in_data = 32'hDEADBEEF; grant = 1; #1;
        checks++; if (req !== 1'b0 || cdb_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass req=%0b cdb_valid=%0b exp=0,0", req, cdb_valid); end
        tick();
        in_valid = 0; #1;
        checks++; if (req !== 1'b1 || cdb_valid !== 1'b1 || count !== 3'd1) begin failures++;
            $display("FAIL single_req req=%0b cdb_valid=%0b count=%0d exp=1,1,1", req, cdb_valid, count); end
        checks++; if (cdb_rob_idx !== 5'd3 || cdb_pd !== 6'd12 || cdb_rd !== 5'd7 || cdb_data !== 32'hDEADBEEF) begin failures++;
            $display("FAIL single_fields got=%0d/%0d/%0d/%h exp=3/12/7/deadbeef", cdb_rob_idx, cdb_pd, cdb_rd, cdb_data); end
        tick();
        grant = 0; #1;
        checks++; if (count !== 3'd0 || req !== 1'b0) begin failures++; $display("FAIL single_drain count=%0d req=%0b exp=0,0", count, req); end
    endtask

    task automatic test_fill_drain();
        grant = 0;
        for (int i = 1; i <= 4; i++) begin drive(1, i); tick(); end
        drive(1, 5); #1;
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL full count=%0d in_ready=%0b exp=4,0", count, in_ready); end
        tick();
        in_valid = 0; #1;
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_reject count=%0d exp=4", count); end
        grant = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'(i)) begin failures++;
                $display("FAIL drain_order i=%0d cdb_valid=%0b data=%0d exp=1,%0d", i, cdb_valid, cdb_data, i); end
            tick();
        end
        grant = 0; #1;
        checks++; if (req !== 1'b0) begin failures++; $display("FAIL drain_empty req=%0b exp=0", req); end
    endtask

    task automatic test_steady();
        grant = 0;
        drive(1, 100); tick(); drive(1, 101); tick();
        grant = 1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 200 + i); #1;
            checks++; if (count !== 3'd2 || cdb_valid !== 1'b1 || cdb_data !== ((i < 2) ? 32'(100 + i) : 32'(198 + i))) begin failures++;
                $display("FAIL steady i=%0d count=%0d cdb_valid=%0b data=%0d", i, count, cdb_valid, cdb_data); end
            tick();
        end
        in_valid = 0; tick(); tick(); grant = 0; #1;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL steady_drain count=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        grant = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 32'h10 + i); tick(); end
        drive(1, 32'hBAD0BAD0); grant = 1; flush = 1; #1;
        checks++; if (cdb_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL flush_cycle cdb_valid=%0b in_ready=%0b exp=0,1", cdb_valid, in_ready); end
        tick();
        flush = 0; in_valid = 0; grant = 0; #1;
        checks++; if (count !== 3'd0 || req !== 1'b0) begin failures++; $display("FAIL flush_after count=%0d req=%0b exp=0,0", count, req); end
        drive(1, 32'h77); tick(); in_valid = 0; grant = 1; #1;
        checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h77) begin failures++;
            $display("FAIL flush_next data=%h valid=%0b exp=77,1", cdb_data, cdb_valid); end
        tick(); grant = 0;
    endtask

    task automatic test_spurious_grant();
        int s0;
        s0 = spurious; grant = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (cdb_valid !== 1'b0 || count !== 3'd0) begin failures++;
                $display("FAIL spurious_grant i=%0d cdb_valid=%0b count=%0d exp=0,0", i, cdb_valid, count); end
            tick();
        end
        grant = 0;
        checks++; if (spurious - s0 !== 5) begin failures++; $display("FAIL spurious_flag got=%0d exp=5", spurious - s0); end
    endtask

    task automatic test_async_reset();
        grant = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 32'h30 + i); tick(); end
        in_valid = 0; grant = 1; #1;
        checks++; if (cdb_valid !== 1'b1) begin failures++; $display("FAIL prereset_valid got=%0b exp=1", cdb_valid); end
        #2 rst = 1; #1;
        checks++; if (req !== 1'b0 || cdb_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd0) begin failures++;
            $display("FAIL async_reset req=%0b cdb_valid=%0b in_ready=%0b count=%0d exp=0,0,0,0", req, cdb_valid, in_ready, count); end
        grant = 0; #1 rst = 0;
        mq.delete();
        drive(1, 32'h55); tick(); in_valid = 0; grant = 1; #1;
        checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'h55) begin failures++;
            $display("FAIL reset_first_push valid=%0b data=%h exp=1,55", cdb_valid, cdb_data); end
        tick(); grant = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 99) < 60), $urandom);
            grant = 1'($urandom_range(0, 99) < 50);
            flush = 1'($urandom_range(0, 99) < 4);
            #1;
            checks++; if (count !== 3'(mq.size()) || req !== (mq.size() != 0) || in_ready !== (mq.size() != DEPTH)) begin failures++;
                $display("FAIL rand_state c=%0d count=%0d req=%0b in_ready=%0b exp_size=%0d", c, count, req, in_ready, mq.size()); end
            checks++; if (cdb_valid !== ((mq.size() != 0) && grant && !flush)) begin failures++;
                $display("FAIL rand_valid c=%0d got=%0b", c, cdb_valid); end
            if (mq.size() != 0) begin
                checks++; if (cdb_rob_idx !== mq[0].rob_idx || cdb_pd !== mq[0].pd || cdb_rd !== mq[0].rd || cdb_data !== mq[0].data) begin failures++;
                    $display("FAIL rand_head c=%0d got=%0d/%0d/%0d/%h exp=%0d/%0d/%0d/%h", c, cdb_rob_idx, cdb_pd, cdb_rd, cdb_data,
                             mq[0].rob_idx, mq[0].pd, mq[0].rd, mq[0].data); end
            end
            tick();
        end
        in_valid = 0; grant = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_steady();
        test_flush();
        test_spurious_grant();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
